// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage: bus widths, load_op bit positions, bus layouts.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD   = 76;
    localparam int MS_TO_WS_BUS_WD   = 70;
    localparam int MS_FWD_BUS_WD     = 38;
    localparam int ES_MUL_RES_BUS_WD = 65;

    // One-hot load_op bit positions
    localparam int LD_B  = 4;
    localparam int LD_H  = 3;
    localparam int LD_W  = 2;
    localparam int LD_BU = 1;
    localparam int LD_HU = 0;

    typedef struct packed {
        logic        res_from_mul;
        logic [4:0]  load_op;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
    } ms_fwd_t;

    typedef struct packed {
        logic        mul_hi_sel;
        logic [63:0] product;
    } mul_res_t;

endpackage

// File: rtl/mem_stage_if.sv
// Bundle of the execute->mem, mem->writeback and forwarding signals around the memory stage.
// Latency: n/a (wiring only).
// Backpressure: valid/allowin on both sides; the forwarding bus has no backpressure.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                         ws_allowin;
    logic                         ms_allowin;
    logic                         es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0]   es_to_ms_bus;
    logic [ES_MUL_RES_BUS_WD-1:0] es_mul_res_bus;
    logic [31:0]                  data_sram_rdata;
    logic                         ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0]   ms_to_ws_bus;
    logic [MS_FWD_BUS_WD-1:0]     ms_fwd_bus;

    // Memory stage side
    modport slave (
        input  ws_allowin,
        input  es_to_ms_valid,
        input  es_to_ms_bus,
        input  es_mul_res_bus,
        input  data_sram_rdata,
        output ms_allowin,
        output ms_to_ws_valid,
        output ms_to_ws_bus,
        output ms_fwd_bus
    );

    // Surrounding pipeline side (execute, SRAM, writeback, decode)
    modport master (
        output ws_allowin,
        output es_to_ms_valid,
        output es_to_ms_bus,
        output es_mul_res_bus,
        output data_sram_rdata,
        input  ms_allowin,
        input  ms_to_ws_valid,
        input  ms_to_ws_bus,
        input  ms_fwd_bus
    );

endinterface

// File: rtl/mem_stage_load_ext.sv
// Load extract: picks the byte/halfword/word addressed by lane out of a read word and extends it.
// Latency: combinational.
// Backpressure: none.
module mem_load_ext
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [4:0]  load_op,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Select the addressed byte and halfword lanes
    always_comb begin
        byte_sel = rdata[7:0];
        case (lane)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            2'd3: byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    end

    // Sign/zero extend according to the one-hot load type; ld.w returns the word as is
    always_comb begin
        value = rdata;
        if (load_op[LD_B])
            value = {{24{byte_sel[7]}}, byte_sel};
        else if (load_op[LD_BU])
            value = {24'd0, byte_sel};
        else if (load_op[LD_H])
            value = {{16{half_sel[15]}}, half_sel};
        else if (load_op[LD_HU])
            value = {16'd0, half_sel};
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: holds one instruction, forms its writeback value from load data, multiplier or ALU.
// Latency: 1 cycle from execute->mem transfer to ms_to_ws_valid; forwarding bus is combinational.
// Backpressure: ms_allowin = !ms_valid || ws_allowin; on stall the instruction and its result are held.
// Optional feature macro: MS_MUL_RES_EN enables the multiply result path (es_mul_res_bus, mul_buf).
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  pif
);

    logic        ms_valid;
    logic        first;
    es_to_ms_t   bus_r;
    logic [31:0] rdata_buf;
    logic [31:0] rdata_eff;
    logic [31:0] load_value;
    logic [31:0] final_result;
    logic        ms_allowin;
    ms_to_ws_t   ws_bus;
    ms_fwd_t     fwd_bus;

`ifdef MS_MUL_RES_EN
    mul_res_t    mul_buf;
    mul_res_t    mul_eff;
`endif

    // The SRAM word and multiplier result are captured in the first cycle, so the stage never waits
    assign ms_allowin = !ms_valid || pif.ws_allowin;

    // Stage occupancy
    always_ff @(posedge clk) begin
        if (reset)
            ms_valid <= 1'b0;
        else if (ms_allowin)
            ms_valid <= pif.es_to_ms_valid;
    end

    // Instruction register; first marks the cycle right after a transfer, when live inputs are valid
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_r <= '0;
            first <= 1'b0;
        end else if (pif.es_to_ms_valid && ms_allowin) begin
            bus_r <= es_to_ms_t'(pif.es_to_ms_bus);
            first <= 1'b1;
        end else begin
            first <= 1'b0;
        end
    end

    // Capture the SRAM read word while it is live so the result survives writeback stalls
    always_ff @(posedge clk) begin
        if (reset)
            rdata_buf <= '0;
        else if (first)
            rdata_buf <= pif.data_sram_rdata;
    end

    assign rdata_eff = first ? pif.data_sram_rdata : rdata_buf;

`ifdef MS_MUL_RES_EN
    // Capture the multiplier pipe output while it is live
    always_ff @(posedge clk) begin
        if (reset)
            mul_buf <= '0;
        else if (first)
            mul_buf <= mul_res_t'(pif.es_mul_res_bus);
    end

    assign mul_eff = first ? mul_res_t'(pif.es_mul_res_bus) : mul_buf;
`endif

    mem_load_ext u_load_ext (
        .rdata   (rdata_eff),
        .lane    (bus_r.alu_result[1:0]),
        .load_op (bus_r.load_op),
        .value   (load_value)
    );

    // Writeback value: load beats multiply beats ALU
    always_comb begin
        final_result = bus_r.alu_result;
        if (|bus_r.load_op)
            final_result = load_value;
`ifdef MS_MUL_RES_EN
        else if (bus_r.res_from_mul)
            final_result = mul_eff.mul_hi_sel ? mul_eff.product[63:32] : mul_eff.product[31:0];
`else
        else if (bus_r.res_from_mul)
            final_result = bus_r.alu_result;
`endif
    end

    // Output bus assembly
    always_comb begin
        ws_bus.gr_we         = bus_r.gr_we;
        ws_bus.dest          = bus_r.dest;
        ws_bus.final_result  = final_result;
        ws_bus.pc            = bus_r.pc;
        fwd_bus.gr_we        = bus_r.gr_we & ms_valid;
        fwd_bus.dest         = bus_r.dest;
        fwd_bus.final_result = final_result;
    end

    assign pif.ms_allowin     = ms_allowin;
    assign pif.ms_to_ws_valid = ms_valid;
    assign pif.ms_to_ws_bus   = ws_bus;
    assign pif.ms_fwd_bus     = fwd_bus;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: load extraction, multiply select, stalls, back-to-back flow, reset.
// Latency: n/a.
// Backpressure: drives ws_allowin directly.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    mem_stage_if pif();

    mem_stage dut (
        .clk   (clk),
        .reset (reset),
        .pif   (pif)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Advance to just after the next rising edge
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [75:0] mk(input logic mul, input logic [4:0] lop, input logic we,
                                       input logic [4:0] dst, input logic [31:0] alu,
                                       input logic [31:0] pc);
        return {mul, lop, we, dst, alu, pc};
    endfunction

    // Transfer one instruction, supply its live SRAM/multiplier data, check the result, drain it
    task automatic run_one(input string tag, input logic [75:0] ins, input logic [31:0] rdata,
                           input logic [64:0] mulr, input logic [31:0] exp_res);
        pif.es_to_ms_valid = 1'b1;
        pif.es_to_ms_bus   = ins;
        step;
        pif.es_to_ms_valid  = 1'b0;
        pif.es_to_ms_bus    = '0;
        pif.data_sram_rdata = rdata;
        pif.es_mul_res_bus  = mulr;
        #1;
        chk({tag, "_vld"}, 76'(pif.ms_to_ws_valid), 76'(1));
        chk(tag, 76'(pif.ms_to_ws_bus[63:32]), 76'(exp_res));
        step;
    endtask

    logic [31:0] mul_lo_exp;
    logic [31:0] mul_hi_exp;

    initial begin
        reset               = 1'b1;
        pif.ws_allowin      = 1'b1;
        pif.es_to_ms_valid  = 1'b0;
        pif.es_to_ms_bus    = '0;
        pif.es_mul_res_bus  = '0;
        pif.data_sram_rdata = '0;
        repeat (2) step;
        reset = 1'b0;
        #1;
        chk("rst_allowin", 76'(pif.ms_allowin), 76'(1));
        chk("rst_valid",   76'(pif.ms_to_ws_valid), 76'(0));
        chk("rst_fwd",     76'(pif.ms_fwd_bus), 76'(0));
        step;
        chk("idle_valid",  76'(pif.ms_to_ws_valid), 76'(0));
        chk("idle_fwd",    76'(pif.ms_fwd_bus), 76'(0));

        // Load extraction
        run_one("ld_b",  mk(1'b0, 5'b10000, 1'b1, 5'd4, 32'h0000_1003, 32'h1c00_0010), 32'h80FF_1234, '0, 32'hFFFF_FF80);
        run_one("ld_bu", mk(1'b0, 5'b00010, 1'b1, 5'd4, 32'h0000_1003, 32'h1c00_0014), 32'h80FF_1234, '0, 32'h0000_0080);
        run_one("ld_h",  mk(1'b0, 5'b01000, 1'b1, 5'd5, 32'h0000_1002, 32'h1c00_0018), 32'h8001_0000, '0, 32'hFFFF_8001);
        run_one("ld_w",  mk(1'b0, 5'b00100, 1'b1, 5'd5, 32'h0000_1002, 32'h1c00_001c), 32'h8001_0000, '0, 32'h8001_0000);
        run_one("ld_b1", mk(1'b0, 5'b10000, 1'b1, 5'd6, 32'h0000_1001, 32'h1c00_0020), 32'h0000_7F00, '0, 32'h0000_007F);

        // ld.hu with full output and forwarding bus check
        pif.es_to_ms_valid = 1'b1;
        pif.es_to_ms_bus   = mk(1'b0, 5'b00001, 1'b1, 5'd9, 32'h0000_1000, 32'h1c00_0024);
        step;
        pif.es_to_ms_valid  = 1'b0;
        pif.data_sram_rdata = 32'h1234_ABCD;
        #1;
        chk("ld_hu_bus", 76'(pif.ms_to_ws_bus), 76'({1'b1, 5'd9, 32'h0000_ABCD, 32'h1c00_0024}));
        chk("ld_hu_fwd", 76'(pif.ms_fwd_bus),   76'({1'b1, 5'd9, 32'h0000_ABCD}));
        step;
        chk("bubble_valid", 76'(pif.ms_to_ws_valid), 76'(0));
        chk("bubble_fwd_we", 76'(pif.ms_fwd_bus[37]), 76'(0));

        // Multiply select
`ifdef MS_MUL_RES_EN
        mul_lo_exp = 32'hFFFF_FFFE;
        mul_hi_exp = 32'h0000_0001;
`else
        mul_lo_exp = 32'h0BAD_0000;
        mul_hi_exp = 32'h0BAD_0000;
`endif
        run_one("mul_lo", mk(1'b1, 5'b00000, 1'b1, 5'd7, 32'h0BAD_0000, 32'h1c00_0028), 32'h0,
                {1'b0, 64'h0000_0001_FFFF_FFFE}, mul_lo_exp);
        run_one("mul_hi", mk(1'b1, 5'b00000, 1'b1, 5'd7, 32'h0BAD_0000, 32'h1c00_002c), 32'h0,
                {1'b1, 64'h0000_0001_FFFF_FFFE}, mul_hi_exp);

        // Stalled ld.w: result must hold while the SRAM word changes
        pif.es_to_ms_valid = 1'b1;
        pif.es_to_ms_bus   = mk(1'b0, 5'b00100, 1'b1, 5'd8, 32'h0000_2000, 32'h1c00_0030);
        step;
        pif.es_to_ms_bus    = mk(1'b0, 5'b00000, 1'b1, 5'd10, 32'h0000_0055, 32'h1c00_0034);
        pif.data_sram_rdata = 32'h1234_5678;
        pif.ws_allowin      = 1'b0;
        #1;
        chk("stall0_res",     76'(pif.ms_to_ws_bus[63:32]), 76'(32'h1234_5678));
        chk("stall0_allowin", 76'(pif.ms_allowin), 76'(0));
        for (int i = 0; i < 3; i++) begin
            step;
            pif.data_sram_rdata = 32'hDEAD_BEEF;
            #1;
            chk("stall_valid",   76'(pif.ms_to_ws_valid), 76'(1));
            chk("stall_res",     76'(pif.ms_to_ws_bus[63:32]), 76'(32'h1234_5678));
            chk("stall_allowin", 76'(pif.ms_allowin), 76'(0));
        end
        pif.ws_allowin = 1'b1;
        #1;
        chk("unstall_allowin", 76'(pif.ms_allowin), 76'(1));
        step;
        pif.es_to_ms_valid = 1'b0;
        #1;
        chk("held_alu_res", 76'(pif.ms_to_ws_bus[63:32]), 76'(32'h0000_0055));
        step;
        chk("drain_valid", 76'(pif.ms_to_ws_valid), 76'(0));

        // Back-to-back ALU ops
        pif.es_to_ms_valid = 1'b1;
        pif.es_to_ms_bus   = mk(1'b0, 5'b00000, 1'b1, 5'd1, 32'd1, 32'h1c00_0040);
        step;
        pif.es_to_ms_bus   = mk(1'b0, 5'b00000, 1'b1, 5'd2, 32'd2, 32'h1c00_0044);
        #1;
        chk("b2b_1", 76'(pif.ms_to_ws_bus[63:32]), 76'(1));
        step;
        pif.es_to_ms_bus   = mk(1'b0, 5'b00000, 1'b1, 5'd3, 32'd3, 32'h1c00_0048);
        #1;
        chk("b2b_2", 76'(pif.ms_to_ws_bus[63:32]), 76'(2));
        chk("b2b_2_vld", 76'(pif.ms_to_ws_valid), 76'(1));
        step;
        pif.es_to_ms_valid = 1'b0;
        #1;
        chk("b2b_3", 76'(pif.ms_to_ws_bus[63:32]), 76'(3));
        step;
        chk("b2b_end_valid", 76'(pif.ms_to_ws_valid), 76'(0));

        // Reset while a load is stalled
        pif.es_to_ms_valid = 1'b1;
        pif.es_to_ms_bus   = mk(1'b0, 5'b00100, 1'b1, 5'd11, 32'h0000_3000, 32'h1c00_0050);
        step;
        pif.es_to_ms_valid  = 1'b0;
        pif.data_sram_rdata = 32'hCAFE_F00D;
        pif.ws_allowin      = 1'b0;
        step;
        chk("rstst_pre_valid", 76'(pif.ms_to_ws_valid), 76'(1));
        reset = 1'b1;
        step;
        reset = 1'b0;
        #1;
        chk("rstst_valid",   76'(pif.ms_to_ws_valid), 76'(0));
        chk("rstst_allowin", 76'(pif.ms_allowin), 76'(1));
        chk("rstst_fwd",     76'(pif.ms_fwd_bus), 76'(0));
        pif.ws_allowin = 1'b1;
        step;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage in-order CPU, between the execute and writeback stages. Accepts one instruction per cycle from execute under a valid/allowin handshake and holds it in a stage register. Produces the final writeback value:
- load data is extracted and extended from the synchronous data-SRAM read port;
- multiply results are taken from the execute-side multiplier pipe;
- all other results are the ALU result.

Drives a forwarding bus back to decode.

## Interface
Parameters: none; bus widths come from the shared header (`ES_TO_MS_BUS_WD`=76, `MS_TO_WS_BUS_WD`=70, `MS_FWD_BUS_WD`=38).
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- ws_allowin  in  1  writeback can accept this cycle
- ms_allowin  out  1  mem stage can accept this cycle
- es_to_ms_valid  in  1  execute presents an instruction
- es_to_ms_bus  in  76  {res_from_mul[75], load_op[74:70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
- es_mul_res_bus  in  65  {mul_hi_sel[64], product[63:0]}
- data_sram_rdata  in  32  read word for the address issued by execute one cycle earlier
- ms_to_ws_valid  out  1  instruction ready for writeback
- ms_to_ws_bus  out  70  {gr_we[69], dest[68:64], final_result[63:32], pc[31:0]}
- ms_fwd_bus  out  38  {gr_we&ms_valid[37], dest[36:32], final_result[31:0]}

## Operation
- Registers: ms_valid, es_to_ms_bus_r, first flag, rdata_buf, mul_buf.
- ms_ready_go=1 (SRAM latency is absorbed by the buffers). ms_allowin = !ms_valid || ws_allowin. ms_to_ws_valid = ms_valid.
- On ms_allowin: ms_valid <= es_to_ms_valid. On es_to_ms_valid && ms_allowin: bus_r <= es_to_ms_bus and first <= 1. Otherwise first <= 0.
- While first=1: rdata_buf <= data_sram_rdata, mul_buf <= es_mul_res_bus. Effective data = first ? live inputs : buffers. This keeps results stable across writeback stalls.
- load_op one-hot: [4] ld.b, [3] ld.h, [2] ld.w, [1] ld.bu, [0] ld.hu. Byte lane = alu_result[1:0]. Halfword lane = alu_result[1].
  - b/bu: byte at lane, sign- or zero-extended to 32.
  - h/hu: halfword, sign- or zero-extended to 32.
  - w: the full word.
- final_result priority: |load_op → load value; res_from_mul → mul_hi_sel ? product[63:32] : product[31:0]; else alu_result.
- gr_we is passed through unchanged. Writeback qualifies it with ms_to_ws_valid.

## Timing
- Reset: ms_valid=0, first=0, bus_r=0, buffers=0. Hence ms_to_ws_valid=0, ms_allowin=1, and ms_fwd_bus=0.
- Latency: 1 cycle from execute→mem transfer to ms_to_ws_valid.
- Throughput: 1 instruction per cycle when ws_allowin=1.
- Stall (ws_allowin=0): bus_r, buffers and outputs are held. first drops after one cycle. final_result is unchanged for the whole stall.
- Back-to-back with ws_allowin=1: a new instruction is captured in the same cycle the old one leaves, and first stays 1.
- Bubble: es_to_ms_valid=0 with ms_allowin=1 clears ms_valid. Bus contents are don't-care.
- Reset asserted mid-stall: the instruction is dropped next edge and all outputs return to reset values.
- Forwarding bus is combinational from the registered state plus the first-cycle live inputs. There is no block signal; the value is always final.

## Configuration
- `MS_MUL_RES_EN` defined: multiply path, mul_buf and es_mul_res_bus usage are present.
- `MS_MUL_RES_EN` undefined: mul_buf is removed and es_mul_res_bus is ignored. res_from_mul instructions write alu_result.

## Structure
- Shared header (mycpu.h) holds the bus widths above and the load_op bit positions.
- Single module. The load-extract logic is natural as sub-module `mem_load_ext` (rdata, lane, load_op → value).

## Test plan
- Reset, then idle: ms_allowin=1, ms_to_ws_valid=0, ms_fwd_bus=0.
- ld.b addr 0x…03, rdata 0x80FF_1234 → result 0xFFFF_FF80. ld.bu at the same address → 0x0000_0080.
- ld.h addr 0x…02, rdata 0x8001_0000 → 0xFFFF_8001. ld.w → 0x8001_0000.
- mul with product 0x0000_0001_FFFF_FFFE: mul_hi_sel=0 → 0xFFFF_FFFE; mul_hi_sel=1 → 0x0000_0001.
- ld.w, then ws_allowin=0 for 3 cycles while rdata changes to 0xDEAD_BEEF → result stays at the first-cycle word. ms_allowin=0 during the stall.
- Three back-to-back ALU ops, results 1, 2, 3, with ws_allowin=1 → 1, 2, 3 on consecutive cycles. Reset during a stalled load → ms_to_ws_valid=0 on the next cycle.
